// File: rtl/hazard_pkg.sv
// Shared types and helpers for the multi-issue hazard/stall controller.
package hazard_pkg;

    localparam int ISSUE_W_DEF = 2;
    localparam int MAX_ISSUE   = 4;
    localparam int SLOT_VEC_W  = 5 * MAX_ISSUE;

    typedef logic [4:0] reg_idx_t;

    // Memory-op class of a decode slot; same encoding decode uses.
    typedef enum logic [1:0] {
        MEM_NONE = 2'd0,
        MEM_LOAD = 2'd1,
        MEM_STOR = 2'd2
    } mem_op_t;

    // Extract the 5-bit register field of slot i from a packed per-slot vector.
    function automatic reg_idx_t slot_reg(input logic [SLOT_VEC_W-1:0] vec, input int i);
        return vec[5*i +: 5];
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard: load-pending counters plus mul/div busy bits,
// with a combinational "source is not ready" lookup for every decode source port.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ISSUE_W  = ISSUE_W_DEF,
    parameter int LOAD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_freeze,
    input  logic                   i_flush,
    input  logic                   i_md_done,
    input  logic [31:0]            i_ld_set,
    input  logic [31:0]            i_md_set,
    input  logic [10*ISSUE_W-1:0]  i_src_idx,
    output logic [2*ISSUE_W-1:0]   o_src_busy,
    output logic                   o_md_any
);

    localparam int PW = $clog2(LOAD_LAT + 1);
    localparam logic [PW-1:0] LAT = PW'(LOAD_LAT);

    logic [PW-1:0] r_pend [32];
    logic [31:0]   r_md_busy;

    // Load countdowns: a new load sets the counter (winning over decrement); freeze holds.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            for (int r = 0; r < 32; r++) r_pend[r] <= '0;
        end else if (!i_freeze) begin
            for (int r = 0; r < 32; r++) begin
                if (i_ld_set[r] && r != 0)
                    r_pend[r] <= LAT;
                else if (r_pend[r] != '0)
                    r_pend[r] <= r_pend[r] - 1'b1;
            end
        end
    end

    // Mul/div busy bits: md_done clears even under freeze; a newly issued md sets its bit.
    always_ff @(posedge clk) begin
        if (rst || i_flush)
            r_md_busy <= '0;
        else if (!i_freeze)
            r_md_busy <= (i_md_done ? 32'h0 : r_md_busy) | (i_md_set & ~32'h1);
        else if (i_md_done)
            r_md_busy <= '0;
    end

    // Source lookup: register 0 is never pending.
    always_comb begin
        o_src_busy = '0;
        for (int p = 0; p < 2*ISSUE_W; p++) begin
            o_src_busy[p] = (i_src_idx[5*p +: 5] != 5'd0) &&
                            ((r_pend[i_src_idx[5*p +: 5]] != '0) || r_md_busy[i_src_idx[5*p +: 5]]);
        end
        o_md_any = |r_md_busy;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Multi-issue hazard controller: per-slot in-order issue decision, pipeline-register
// stall enables and a saturating count of IF/ID stall cycles.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ISSUE_W  = ISSUE_W_DEF,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ISSUE_W-1:0]    de_valid,
    input  logic [5*ISSUE_W-1:0]  de_rs,
    input  logic [5*ISSUE_W-1:0]  de_rt,
    input  logic [5*ISSUE_W-1:0]  de_rd,
    input  logic [ISSUE_W-1:0]    de_is_load,
    input  logic [ISSUE_W-1:0]    de_is_store,
    input  logic [ISSUE_W-1:0]    de_is_md,
    input  logic                  md_done_i,
    input  logic                  if_stall_i,
    input  logic                  ex_stall_i,
    input  logic                  mem_stall_i,
    input  logic                  flush_i,
    output logic [ISSUE_W-1:0]    de_issue_o,
    output logic                  if_id_stall_o,
    output logic                  id_ex_stall_o,
    output logic                  ex_mem_stall_o,
    output logic [CNT_W-1:0]      stall_cycles_o
);

    logic                    w_freeze;
    logic [SLOT_VEC_W-1:0]   w_rs_pad, w_rt_pad, w_rd_pad;
    logic [10*ISSUE_W-1:0]   w_src_idx;
    logic [2*ISSUE_W-1:0]    w_src_busy;
    logic                    w_md_any;
    logic [ISSUE_W-1:0]      w_haz, w_issue;
    logic [31:0]             w_ld_set, w_md_set, w_rd_mask;
    logic                    w_chain, w_prev_md, w_prev_mem, w_st_issued;
    reg_idx_t                w_rs, w_rt, w_rd;
    mem_op_t                 w_op;
    logic                    r_store_q;
    logic [CNT_W-1:0]        r_stall_cnt;

    assign w_freeze = mem_stall_i;
    assign w_rs_pad = SLOT_VEC_W'(de_rs);
    assign w_rt_pad = SLOT_VEC_W'(de_rt);
    assign w_rd_pad = SLOT_VEC_W'(de_rd);

    // Pack both sources of every slot into the scoreboard lookup ports (rs even, rt odd).
    always_comb begin
        w_src_idx = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_src_idx[10*i +: 5]     = slot_reg(w_rs_pad, i);
            w_src_idx[10*i + 5 +: 5] = slot_reg(w_rt_pad, i);
        end
    end

    hazard_scoreboard #(
        .ISSUE_W  (ISSUE_W),
        .LOAD_LAT (LOAD_LAT)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_freeze   (w_freeze),
        .i_flush    (flush_i),
        .i_md_done  (md_done_i),
        .i_ld_set   (w_ld_set),
        .i_md_set   (w_md_set),
        .i_src_idx  (w_src_idx),
        .o_src_busy (w_src_busy),
        .o_md_any   (w_md_any)
    );

    // Walk slots oldest-first; accumulators only collect state from slots that issue,
    // and the issue chain breaks at the first slot that cannot go.
    always_comb begin
        w_issue     = '0;
        w_haz       = '0;
        w_ld_set    = '0;
        w_md_set    = '0;
        w_rd_mask   = '0;
        w_prev_md   = 1'b0;
        w_prev_mem  = 1'b0;
        w_st_issued = 1'b0;
        w_rs        = '0;
        w_rt        = '0;
        w_rd        = '0;
        w_op        = MEM_NONE;
        w_chain     = ~w_freeze & ~if_stall_i & ~ex_stall_i & ~flush_i;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_rs = slot_reg(w_rs_pad, i);
            w_rt = slot_reg(w_rt_pad, i);
            w_rd = slot_reg(w_rd_pad, i);
            w_op = de_is_load[i] ? MEM_LOAD : (de_is_store[i] ? MEM_STOR : MEM_NONE);
            w_haz[i] = de_valid[i] & (
                       w_src_busy[2*i] | w_src_busy[2*i+1]
                     | (de_is_md[i] & (w_md_any | w_prev_md))
                     | ((w_op == MEM_LOAD) & r_store_q)
                     | ((w_op != MEM_NONE) & w_prev_mem)
                     | ((w_rs != 5'd0) & w_rd_mask[w_rs])
                     | ((w_rt != 5'd0) & w_rd_mask[w_rt]));
            w_chain    = w_chain & de_valid[i] & ~w_haz[i];
            w_issue[i] = w_chain;
            if (w_chain) begin
                w_prev_md   = w_prev_md | de_is_md[i];
                w_prev_mem  = w_prev_mem | (w_op != MEM_NONE);
                w_st_issued = w_st_issued | (w_op == MEM_STOR);
                if (w_rd != 5'd0) begin
                    w_rd_mask[w_rd] = 1'b1;
                    if (w_op == MEM_LOAD) w_ld_set[w_rd] = 1'b1;
                    if (de_is_md[i])      w_md_set[w_rd] = 1'b1;
                end
            end
        end
    end

    assign de_issue_o     = w_issue;
    assign if_id_stall_o  = w_freeze | if_stall_i | ex_stall_i | (|(de_valid & ~w_issue));
    assign id_ex_stall_o  = mem_stall_i;
    assign ex_mem_stall_o = mem_stall_i;
    assign stall_cycles_o = r_stall_cnt;

    // Remember whether a store entered EX, so a following load waits one cycle.
    always_ff @(posedge clk) begin
        if (rst || flush_i)
            r_store_q <= 1'b0;
        else if (!w_freeze)
            r_store_q <= w_st_issued;
    end

    // Saturating count of cycles in which IF/ID is held, including frozen cycles.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (if_id_stall_o && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: two instances (LOAD_LAT=1 with a 6-bit counter, LOAD_LAT=2
// with a 32-bit counter) share one stimulus and are compared each cycle to a rule-level model.
module tb_pipe_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  de_valid, de_is_load, de_is_store, de_is_md;
    logic [9:0]  de_rs, de_rt, de_rd;
    logic        md_done_i, if_stall_i, ex_stall_i, mem_stall_i, flush_i;

    logic [1:0]  iss0, iss1;
    logic        ifid0, ifid1, idex0, idex1, exmem0, exmem1;
    logic [5:0]  cnt0;
    logic [31:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // model state, index 0 = LOAD_LAT 1, index 1 = LOAD_LAT 2
    int              pend [2][32];
    bit              busy [2][32];
    bit              sq   [2];
    longint unsigned mcnt [2];
    longint unsigned cmax [2] = '{63, 64'hFFFF_FFFF};
    int              lat  [2] = '{1, 2};
    logic [1:0]      exp_iss  [2];
    bit              exp_ifid [2];
    longint unsigned base;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.ISSUE_W(2), .LOAD_LAT(1), .CNT_W(6)) u_dut0 (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs(de_rs), .de_rt(de_rt), .de_rd(de_rd),
        .de_is_load(de_is_load), .de_is_store(de_is_store), .de_is_md(de_is_md),
        .md_done_i(md_done_i), .if_stall_i(if_stall_i), .ex_stall_i(ex_stall_i),
        .mem_stall_i(mem_stall_i), .flush_i(flush_i), .de_issue_o(iss0),
        .if_id_stall_o(ifid0), .id_ex_stall_o(idex0), .ex_mem_stall_o(exmem0),
        .stall_cycles_o(cnt0));

    pipe_hazard_ctrl #(.ISSUE_W(2), .LOAD_LAT(2), .CNT_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs(de_rs), .de_rt(de_rt), .de_rd(de_rd),
        .de_is_load(de_is_load), .de_is_store(de_is_store), .de_is_md(de_is_md),
        .md_done_i(md_done_i), .if_stall_i(if_stall_i), .ex_stall_i(ex_stall_i),
        .mem_stall_i(mem_stall_i), .flush_i(flush_i), .de_issue_o(iss1),
        .if_id_stall_o(ifid1), .id_ex_stall_o(idex1), .ex_mem_stall_o(exmem1),
        .stall_cycles_o(cnt1));

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, exp, $time);
        end
    endtask

    // Decide issue for every slot from the architectural rules.
    task automatic model_eval(input int m);
        bit ok;
        bit anyb;
        bit h;
        int rs, rt, rd, rdj;
        logic [1:0] iss;
        ok   = !mem_stall_i && !if_stall_i && !ex_stall_i && !flush_i;
        anyb = 0;
        for (int r = 0; r < 32; r++) anyb |= busy[m][r];
        iss = 2'b00;
        for (int s = 0; s < 2; s++) begin
            rs = de_rs[5*s +: 5];
            rt = de_rt[5*s +: 5];
            rd = de_rd[5*s +: 5];
            h  = 0;
            if (rs != 0 && (pend[m][rs] > 0 || busy[m][rs])) h = 1;
            if (rt != 0 && (pend[m][rt] > 0 || busy[m][rt])) h = 1;
            if (de_is_md[s] && anyb) h = 1;
            if (de_is_load[s] && sq[m]) h = 1;
            for (int j = 0; j < s; j++) begin
                if (iss[j]) begin
                    rdj = de_rd[5*j +: 5];
                    if (de_is_md[s] && de_is_md[j]) h = 1;
                    if ((de_is_load[s] || de_is_store[s]) && (de_is_load[j] || de_is_store[j])) h = 1;
                    if (rdj != 0 && (rs == rdj || rt == rdj)) h = 1;
                end
            end
            iss[s] = ok && de_valid[s] && !h && (s == 0 || iss[s-1]);
        end
        exp_iss[m]  = iss;
        exp_ifid[m] = mem_stall_i || if_stall_i || ex_stall_i || ((de_valid & ~iss) != 2'b00);
    endtask

    // Advance the model by one clock edge.
    task automatic model_update(input int m);
        if (rst) begin
            for (int r = 0; r < 32; r++) begin pend[m][r] = 0; busy[m][r] = 0; end
            sq[m] = 0; mcnt[m] = 0;
            return;
        end
        if (exp_ifid[m] && mcnt[m] < cmax[m]) mcnt[m]++;
        if (flush_i) begin
            for (int r = 0; r < 32; r++) begin pend[m][r] = 0; busy[m][r] = 0; end
            sq[m] = 0;
            return;
        end
        if (mem_stall_i) begin
            if (md_done_i) for (int r = 0; r < 32; r++) busy[m][r] = 0;
            return;
        end
        for (int r = 0; r < 32; r++) if (pend[m][r] > 0) pend[m][r]--;
        if (md_done_i) for (int r = 0; r < 32; r++) busy[m][r] = 0;
        sq[m] = 0;
        for (int s = 0; s < 2; s++) begin
            if (exp_iss[m][s]) begin
                if (de_is_load[s] && de_rd[5*s +: 5] != 0) pend[m][de_rd[5*s +: 5]] = lat[m];
                if (de_is_md[s]   && de_rd[5*s +: 5] != 0) busy[m][de_rd[5*s +: 5]] = 1;
                if (de_is_store[s]) sq[m] = 1;
            end
        end
    endtask

    // Sample outputs mid-cycle and compare both instances against the model.
    task automatic settle();
        #2;
        model_eval(0);
        model_eval(1);
        chk("m0_issue", iss0, exp_iss[0]);
        chk("m0_if_id", ifid0, exp_ifid[0]);
        chk("m0_id_ex", idex0, mem_stall_i);
        chk("m0_ex_mem", exmem0, mem_stall_i);
        chk("m0_cnt", cnt0, mcnt[0]);
        chk("m1_issue", iss1, exp_iss[1]);
        chk("m1_if_id", ifid1, exp_ifid[1]);
        chk("m1_id_ex", idex1, mem_stall_i);
        chk("m1_ex_mem", exmem1, mem_stall_i);
        chk("m1_cnt", cnt1, mcnt[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle_in();
        de_valid = 0; de_is_load = 0; de_is_store = 0; de_is_md = 0;
        de_rs = 0; de_rt = 0; de_rd = 0;
        md_done_i = 0; if_stall_i = 0; ex_stall_i = 0; mem_stall_i = 0; flush_i = 0;
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 mul/div
    task automatic slot(input int s, input int rs, input int rt, input int rd, input int kind);
        de_valid[s]       = 1'b1;
        de_rs[5*s +: 5]   = 5'(rs);
        de_rt[5*s +: 5]   = 5'(rt);
        de_rd[5*s +: 5]   = 5'(rd);
        de_is_load[s]     = (kind == 1);
        de_is_store[s]    = (kind == 2);
        de_is_md[s]       = (kind == 3);
    endtask

    initial begin
        int k;
        rst = 1'b1;
        idle_in();
        #1;
        tick();
        rst = 1'b0;

        // reset state
        settle();
        chk("rst_issue", iss0, 0); chk("rst_ifid", ifid0, 0); chk("rst_idex", idex0, 0);
        chk("rst_cnt0", cnt0, 0); chk("rst_cnt1", cnt1, 0);
        tick();

        // load-use
        idle_in(); slot(0, 1, 2, 5, 1);
        settle(); chk("lu_load", iss0, 2'b01); tick();
        idle_in(); slot(0, 5, 2, 6, 0);
        settle(); chk("lu_bubble", iss0, 2'b00); chk("lu_bubble_ifid", ifid0, 1); chk("lu2_bubble", iss1, 2'b00); tick();
        settle(); chk("lu_t2", iss0, 2'b01); chk("lu2_t2", iss1, 2'b00); tick();
        settle(); chk("lu2_t3", iss1, 2'b01); tick();

        // intra-bundle RAW
        idle_in(); slot(0, 1, 2, 3, 0); slot(1, 3, 4, 7, 0);
        settle(); chk("raw_partial", iss0, 2'b01); chk("raw_ifid", ifid0, 1); tick();
        idle_in(); slot(0, 3, 4, 7, 0);
        settle(); chk("raw_replay", iss0, 2'b01); chk("raw_replay_ifid", ifid0, 0); tick();
        idle_in(); slot(0, 1, 2, 0, 0); slot(1, 0, 0, 7, 0);
        settle(); chk("raw_r0", iss0, 2'b11); chk("raw_r0_m1", iss1, 2'b11); tick();

        // store-load
        idle_in(); slot(0, 1, 2, 0, 2);
        settle(); chk("sw_issue", iss0, 2'b01); tick();
        idle_in(); slot(0, 1, 2, 9, 1);
        settle(); chk("sl_block", iss0, 2'b00); tick();
        settle(); chk("sl_go", iss0, 2'b01); tick();
        idle_in(); slot(0, 1, 2, 0, 2); slot(1, 1, 2, 10, 1);
        settle(); chk("sw_lw_bundle", iss0, 2'b01); tick();
        idle_in(); repeat (3) cyc();

        // mul/div
        slot(0, 1, 2, 8, 3);
        settle(); chk("md_issue", iss0, 2'b01); tick();
        idle_in(); slot(0, 8, 1, 11, 0);
        settle(); chk("md_wait1", iss0, 2'b00); tick();
        settle(); chk("md_wait2", iss0, 2'b00); tick();
        md_done_i = 1;
        settle(); chk("md_done_cycle", iss0, 2'b00); tick();
        md_done_i = 0;
        settle(); chk("md_after_done", iss0, 2'b01); tick();
        idle_in(); slot(0, 1, 2, 12, 3);
        settle(); chk("md2_issue", iss0, 2'b01); tick();
        idle_in(); slot(0, 1, 2, 13, 3);
        settle(); chk("md_struct", iss0, 2'b00); tick();
        idle_in(); md_done_i = 1; cyc(); md_done_i = 0; repeat (3) cyc();

        // freeze with a pending load
        slot(0, 1, 2, 5, 1);
        settle(); chk("fz_load", iss0, 2'b01); tick();
        idle_in(); slot(0, 5, 1, 6, 0); mem_stall_i = 1;
        base = mcnt[0];
        for (int c = 0; c < 3; c++) begin
            settle();
            chk("fz_issue", iss0, 2'b00); chk("fz_ifid", ifid0, 1);
            chk("fz_idex", idex0, 1); chk("fz_exmem", exmem0, 1);
            tick();
        end
        mem_stall_i = 0;
        settle(); chk("fz_cnt", cnt0, base + 3); chk("fz_release", iss0, 2'b00); chk("fz_release_ifid", ifid0, 1); tick();
        settle(); chk("fz_go", iss0, 2'b01); tick();
        idle_in(); repeat (4) cyc();

        // flush clears load and mul/div tracking
        slot(0, 1, 2, 5, 1); slot(1, 2, 3, 8, 3);
        settle(); chk("fl_issue", iss0, 2'b11); chk("fl_issue_m1", iss1, 2'b11); tick();
        idle_in(); slot(0, 5, 8, 14, 0); slot(1, 8, 0, 15, 0); flush_i = 1;
        settle(); chk("fl_force0", iss0, 2'b00); chk("fl_force1", iss1, 2'b00); tick();
        flush_i = 0;
        settle(); chk("fl_after0", iss0, 2'b11); chk("fl_after1", iss1, 2'b11); tick();
        idle_in(); repeat (2) cyc();

        // reset mid-sequence discards pending state
        slot(0, 1, 2, 5, 1); slot(1, 1, 2, 8, 3); cyc();
        idle_in(); slot(0, 5, 8, 9, 0); rst = 1; cyc(); rst = 0;
        idle_in();
        settle();
        chk("mr_issue", iss0, 0); chk("mr_ifid", ifid0, 0); chk("mr_idex", idex0, 0);
        chk("mr_exmem", exmem0, 0); chk("mr_cnt0", cnt0, 0); chk("mr_cnt1", cnt1, 0);
        tick();
        slot(0, 5, 8, 9, 0);
        settle(); chk("mr_discard0", iss0, 2'b01); chk("mr_discard1", iss1, 2'b01); tick();

        // counter saturation on the 6-bit instance
        idle_in(); if_stall_i = 1;
        repeat (70) cyc();
        if_stall_i = 0;
        settle(); chk("sat_cnt0", cnt0, 63); chk("sat_cnt1", cnt1, 70); tick();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle_in();
            for (int s = 0; s < 2; s++) begin
                k = $urandom_range(0, 5);
                k = (k < 3) ? 0 : k - 2;
                slot(s, $urandom_range(0, 7), $urandom_range(0, 7),
                     (k == 2) ? 0 : $urandom_range(0, 7), k);
                de_valid[s] = ($urandom_range(0, 3) != 0);
            end
            md_done_i   = ($urandom_range(0, 9) == 0);
            if_stall_i  = ($urandom_range(0, 11) == 0);
            ex_stall_i  = ($urandom_range(0, 11) == 0);
            mem_stall_i = ($urandom_range(0, 9) == 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            rst         = ($urandom_range(0, 199) == 0);
            cyc();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
